// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, SB_TICK-long stop.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic            parity_reg, parity_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // tx_next is only ever changed at bit boundaries, so the registered line cannot glitch.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    tx_next      = tx_reg;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          n_next     = '0;
          b_next     = tx_din;
          tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^tx_din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 5'd15) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 5'd15) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == 3'(DBIT-1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
              tx_next    = parity_reg;
`else
              state_next = STOP;
              tx_next    = 1'b1;
`endif
            end else begin
              n_next  = n_reg + 3'd1;
              // b_reg[1] is the bit that becomes the LSB after this shift
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == 5'd15) begin
            state_next = STOP;
            s_next     = '0;
            tx_next    = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_reg == 5'(SB_TICK-1)) begin
            state_next   = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random frames checked against a per-tick line model.
// Two instances: SB_TICK=16 (most tests) and SB_TICK=32 (long stop bit).
module tb_uart_tx_ctrl;
  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       tx_start16 = 1'b0;
  logic       tx_start32 = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       tx16, busy16, done16;
  logic       tx32, busy32, done32;

  int tests = 0;
  int fails = 0;
  int tick_period = 4;
  bit tick_en = 1'b0;
  int tick_cnt = 0;

  uart_tx_ctrl #(.DBIT(DBIT), .SB_TICK(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start16), .tx_din(tx_din),
    .tx(tx16), .tx_busy(busy16), .tx_done_tick(done16)
  );

  uart_tx_ctrl #(.DBIT(DBIT), .SB_TICK(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start32), .tx_din(tx_din),
    .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32)
  );

  always #5 clk = ~clk;

  // s_tick changes on the falling edge so it is stable around every rising edge.
  always @(negedge clk) begin
    if (!tick_en) begin
      s_tick = 1'b0;
      tick_cnt = 0;
    end else if (tick_cnt >= tick_period - 1) begin
      tick_cnt = 0;
      s_tick = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: just after the falling edge, well away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected line level during tick period p (0-based) of a frame carrying d.
  function automatic logic exp_line(input logic [7:0] d, input int p);
    if (p < 16) return 1'b0;
    p -= 16;
    if (p < 16 * DBIT) return d[p / 16];
    p -= 16 * DBIT;
`ifdef UART_TX_PARITY_EN
    if (p < 16) return ^d;
    p -= 16;
`endif
    return 1'b1;
  endfunction

  function automatic int frame_ticks(input int sb);
    return 16 * (1 + DBIT + PBITS) + sb;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) tx_start32 = v;
    else tx_start16 = v;
  endtask

  // Sends one frame and follows the line tick by tick until the frame should be over.
  task automatic run_frame(input bit sel, input logic [7:0] data, input bit hold,
                           input bit align, input int inj_tick, input string tag);
    int sb, total, ticks, mism, first_p, done_cnt, done_at, cyc;
    logic line, busy, done, first_obs, first_exp;
    bit injected;
    sb = sel ? 32 : 16;
    total = frame_ticks(sb);
    ticks = 0; mism = 0; first_p = -1; done_cnt = 0; done_at = -1; cyc = 0;
    first_obs = 1'b0; first_exp = 1'b0; injected = 1'b0;
    if (align) begin
      while (!s_tick && cyc < 20) begin step(); cyc++; end
      cyc = 0;
    end
    check({tag, " idle_before"}, sel ? busy32 : busy16, 0);
    tx_din = data;
    set_start(sel, 1'b1);
    step();
    if (!hold) set_start(sel, 1'b0);
    tx_din = 8'($urandom);
    while (ticks < total && cyc < total * 8 + 64) begin
      line = sel ? tx32 : tx16;
      busy = sel ? busy32 : busy16;
      done = sel ? done32 : done16;
      if (line !== exp_line(data, ticks) || busy !== 1'b1) begin
        if (mism == 0) begin
          first_p = ticks; first_obs = line; first_exp = exp_line(data, ticks);
        end
        mism++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = ticks + 1;
      end
      if (injected && !hold) set_start(sel, 1'b0);
      if (inj_tick >= 0 && ticks == inj_tick && !injected) begin
        tx_din = 8'hFF;
        set_start(sel, 1'b1);
        injected = 1'b1;
      end
      if (s_tick) ticks++;
      step();
      cyc++;
    end
    check({tag, " ticks_seen"}, ticks, total);
    if (mism != 0)
      $display("  %s first diff at tick %0d: tx=%b want %b", tag, first_p, first_obs, first_exp);
    check({tag, " line_errors"}, mism, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_tick"}, done_at, total);
    check({tag, " busy_after"}, sel ? busy32 : busy16, 0);
    check({tag, " tx_after"}, sel ? tx32 : tx16, 1);
    $display("[TB] frame %s data=%02h ticks=%0d done_at=%0d line_errors=%0d", tag, data, total, done_at, mism);
  endtask

  initial begin
    int ticks, cyc, busy_seen, done_seen;
    reset_n = 1'b0;
    tick_en = 1'b1;
    repeat (3) step();
    check("reset tx16", tx16, 1);
    check("reset busy16", busy16, 0);
    check("reset done16", done16, 0);
    check("reset tx32", tx32, 1);
    check("reset busy32", busy32, 0);
    reset_n = 1'b1;
    step();

    tick_period = 4;
    run_frame(1'b0, 8'hA5, 1'b0, 1'b0, -1, "a5");
    run_frame(1'b0, 8'h07, 1'b0, 1'b0, -1, "07");

    tick_period = 3;
    run_frame(1'b0, 8'($urandom), 1'b0, 1'b1, -1, "start_on_tick");

    tick_period = 4;
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, 60, "ignore_start");
    busy_seen = 0;
    repeat (40) begin step(); if (busy16 !== 1'b0) busy_seen++; end
    check("ignore_start no_second_frame", busy_seen, 0);

    // Abort a frame with reset at tick 70.
    tx_din = 8'h96;
    tx_start16 = 1'b1;
    step();
    tx_start16 = 1'b0;
    ticks = 0; cyc = 0; done_seen = 0;
    while (ticks < 70 && cyc < 1000) begin
      if (done16 === 1'b1) done_seen++;
      if (s_tick) ticks++;
      step();
      cyc++;
    end
    check("abort busy_before", busy16, 1);
    reset_n = 1'b0;
    #1;
    check("abort tx", tx16, 1);
    check("abort busy", busy16, 0);
    repeat (3) begin step(); if (done16 === 1'b1) done_seen++; end
    check("abort no_done", done_seen, 0);
    reset_n = 1'b1;
    step();
    $display("[TB] abort at tick %0d done_pulses=%0d", ticks, done_seen);
    run_frame(1'b0, 8'h55, 1'b0, 1'b0, -1, "after_reset");

    run_frame(1'b0, 8'h81, 1'b1, 1'b0, -1, "b2b_1");
    run_frame(1'b0, 8'h81, 1'b1, 1'b0, -1, "b2b_2");
    run_frame(1'b0, 8'h81, 1'b0, 1'b0, -1, "b2b_3");

    run_frame(1'b1, 8'h00, 1'b0, 1'b0, -1, "sb32");

    for (int i = 0; i < 10; i++) begin
      tick_period = $urandom_range(1, 6);
      run_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 150) : -1, "random");
    end

    tx_start16 = 1'b0;
    tx_start32 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick periods, legal values 16/24/32 (1, 1.5, 2 stop bits).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_tick  input  1  one-cycle oversampling tick, 16 per bit period (driven by the baud Timer done output).
REQ-006 tx_start  input  1  request to send tx_din; sampled only in IDLE.
REQ-007 tx_din  input  DBIT  data word to transmit, LSB first.
REQ-008 tx  output  1  serial line, registered, idle high.
REQ-009 tx_busy  output  1  high in every state except IDLE.
REQ-010 tx_done_tick  output  1  one-cycle pulse at frame completion.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 IDLE: on tx_start=1 the block SHALL latch tx_din into a shift register, clear tick count s and bit index n, and enter START on the next edge; tx=0 from that edge.
REQ-013 tx_start SHALL be ignored in all states other than IDLE; tx_din SHALL be ignored after the latch.
REQ-014 Tick counter s (5 bits) SHALL increment only on cycles with s_tick=1; state is otherwise held.
REQ-015 START: on s_tick with s==15 SHALL enter DATA with s=0, n=0, tx=shift-register LSB.
REQ-016 DATA: on s_tick with s==15 SHALL shift right by one; if n==DBIT-1 enter PARITY (macro defined) or STOP (macro undefined), else n=n+1; s=0.
REQ-017 STOP: tx=1; on s_tick with s==SB_TICK-1 SHALL enter IDLE and assert tx_done_tick for exactly that one cycle.
REQ-018 Each start/data/parity bit SHALL last exactly 16 s_tick periods; stop SHALL last exactly SB_TICK periods.
REQ-019 tx_start=1 on the cycle tx_done_tick=1 SHALL be ignored; a new frame is accepted the following cycle (IDLE), giving no gap beyond one clock.
REQ-020 s_tick asserted on the same cycle as tx_start in IDLE SHALL not be counted toward START.
REQ-021 tx SHALL never glitch: it changes only on clock edges coincident with state or bit transitions.

Reset
REQ-022 reset_n=0 SHALL force, asynchronously: state=IDLE, s=0, n=0, shift register=0, tx=1, tx_busy=0, tx_done_tick=0.
REQ-023 Reset mid-frame SHALL abort the frame with no tx_done_tick; tx returns high immediately.
REQ-024 After reset release the first accepted tx_start SHALL produce a complete, correct frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state present, transmitted for 16 ticks after the last data bit, value = XOR of the latched DBIT data bits (even parity), then STOP.
REQ-026 Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-027 DBIT=8, SB_TICK=16, s_tick every 4 clocks, tx_din=0xA5 -> tx: 0 for 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each, 1 for 16 ticks; tx_done_tick one cycle at tick 160; tx_busy high throughout.
REQ-028 UART_TX_PARITY_EN defined: tx_din=0xA5 -> parity bit 0; tx_din=0x07 -> parity bit 1; done at tick 176.
REQ-029 tx_start pulsed with 0xFF mid-DATA of a 0x3C frame -> 0x3C frame unaltered, no second frame.
REQ-030 reset_n low at tick 70 of a frame -> tx=1, tx_busy=0 same cycle, no done pulse; next frame 0x55 correct.
REQ-031 tx_start held high continuously with tx_din=0x81 -> back-to-back frames, each 160 ticks, exactly one done pulse per frame.
REQ-032 SB_TICK=32, tx_din=0x00 -> stop high for 32 ticks, done at tick 176.
